// File: rtl/sdrc_burst_initiator_pkg.sv
// Shared types and widths for the SDRC burst initiator and its word buffer.
package sdrc_burst_initiator_pkg;

    localparam int SDRC_ADDR_W = 21;
    localparam int SDRC_DATA_W = 32;
    localparam int SDRC_LEN_W  = 7;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        ISSUE = 3'd2,
        WRITE = 3'd3,
        READ  = 3'd4
    } state_t;

endpackage

// File: rtl/sdrc_burst_initiator_if.sv
// Host-side command, write-data and read-data bundle of the burst initiator.
// Handshakes: a transfer happens on a rising clock edge where valid and ready are both 1; read data has no ready.
interface sdrc_burst_initiator_if;
    import sdrc_burst_initiator_pkg::*;

    logic                   cmd_valid;
    logic                   cmd_ready;
    logic                   cmd_write;
    logic [SDRC_ADDR_W-1:0] cmd_addr;
    logic [5:0]             cmd_len;
    logic                   wdata_valid;
    logic                   wdata_ready;
    logic [SDRC_DATA_W-1:0] wdata;
    logic                   rdata_valid;
    logic [SDRC_DATA_W-1:0] rdata;
    logic                   rdata_last;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_len, wdata_valid, wdata,
        input  cmd_ready, wdata_ready, rdata_valid, rdata, rdata_last
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, wdata_valid, wdata,
        output cmd_ready, wdata_ready, rdata_valid, rdata, rdata_last
    );

endinterface

// File: rtl/sdrc_burst_initiator_word_fifo.sv
// Synchronous word FIFO with show-ahead head; flush empties it in one cycle.
module sdrc_word_fifo
    import sdrc_burst_initiator_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int W     = SDRC_DATA_W
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [W-1:0]          din,
    output logic [W-1:0]          head,
    output logic [SDRC_LEN_W-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && (count < SDRC_LEN_W'(DEPTH)) && !flush;
    assign do_pop  = pop && (count != '0) && !flush;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + SDRC_LEN_W'(1);
                2'b01:   count <= count - SDRC_LEN_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sdrc_burst_initiator.sv
// Buffers a host write burst or issues a read burst to an SDRAM controller, with a completion timeout.
module sdrc_burst_initiator
    import sdrc_burst_initiator_pkg::*;
#(
    parameter int MAX_WORDS      = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clock,
    input  logic                   reset_n,
    sdrc_burst_initiator_if.slave  host,
    output logic                   busy,
    output logic                   error,
    output state_t                 fsm_state,
    output logic                   sdrc_wr_n,
    output logic                   sdrc_rd_n,
    output logic [SDRC_ADDR_W-1:0] sdrc_addr,
    output logic [SDRC_LEN_W-1:0]  sdrc_data_len,
    output logic [3:0]             sdrc_dqm,
    output logic [SDRC_DATA_W-1:0] sdrc_data_write,
    output logic                   sdrc_self_refresh,
    output logic                   sdrc_power_down,
    input  logic [SDRC_DATA_W-1:0] sdrc_data_read,
    input  logic                   sdrc_init_done,
    input  logic                   sdrc_busy_n,
    input  logic                   sdrc_rd_valid,
    input  logic                   sdrc_wrd_ack
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t                 state_q, state_d;
    logic [SDRC_ADDR_W-1:0] addr_q;
    logic [5:0]             len_q;
    logic                   write_q;
    logic [SDRC_LEN_W-1:0]  word_cnt_q;
    logic [TW-1:0]          tmr_q;
    logic [5:0]             len_clamped;
    logic                   accept;
    logic                   fifo_push, fifo_pop, fifo_flush;
    logic [SDRC_LEN_W-1:0]  fifo_count;
    logic                   word_event;
    logic                   last_word;
    logic                   tmr_hit;
    logic                   timeout;

    assign len_clamped = ({1'b0, host.cmd_len} >= SDRC_LEN_W'(MAX_WORDS))
                         ? 6'(MAX_WORDS - 1) : host.cmd_len;
    assign accept      = host.cmd_valid && host.cmd_ready;
    assign word_event  = ((state_q == WRITE) && sdrc_wrd_ack) || ((state_q == READ) && sdrc_rd_valid);
    assign last_word   = (word_cnt_q == {1'b0, len_q});
    assign tmr_hit     = (tmr_q == TW'(TIMEOUT_CYCLES - 1));

    assign busy              = (state_q != IDLE);
    assign fsm_state         = state_q;
    assign sdrc_addr         = addr_q;
    assign sdrc_data_len     = {1'b0, len_q};
    assign sdrc_dqm          = 4'b0000;
    assign sdrc_self_refresh = 1'b0;
    assign sdrc_power_down   = 1'b0;

    sdrc_word_fifo #(.DEPTH(MAX_WORDS), .W(SDRC_DATA_W)) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .flush   (fifo_flush),
        .din     (host.wdata),
        .head    (sdrc_data_write),
        .count   (fifo_count)
    );

    always_comb begin
        state_d          = state_q;
        host.cmd_ready   = 1'b0;
        host.wdata_ready = 1'b0;
        fifo_push        = 1'b0;
        fifo_pop         = 1'b0;
        fifo_flush       = 1'b0;
        sdrc_wr_n        = 1'b1;
        sdrc_rd_n        = 1'b1;
        timeout          = 1'b0;
        case (state_q)
            IDLE: begin
                // Gated by reset_n so cmd_ready reads 0 while reset is held.
                host.cmd_ready = sdrc_init_done && reset_n;
                if (host.cmd_valid && sdrc_init_done && reset_n) begin
                    state_d = host.cmd_write ? FILL : ISSUE;
                end
            end
            FILL: begin
                host.wdata_ready = (fifo_count < ({1'b0, len_q} + SDRC_LEN_W'(1)));
                if (host.wdata_valid && host.wdata_ready) begin
                    fifo_push = 1'b1;
                    if (fifo_count == {1'b0, len_q}) state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (sdrc_busy_n) begin
                    sdrc_wr_n = !write_q;
                    sdrc_rd_n = write_q;
                    state_d   = write_q ? WRITE : READ;
                end
            end
            WRITE, READ: begin
                if (word_event) begin
                    fifo_pop = (state_q == WRITE);
                    if (last_word) state_d = IDLE;
                end else if (tmr_hit) begin
                    timeout    = 1'b1;
                    fifo_flush = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= IDLE;
            addr_q           <= '0;
            len_q            <= '0;
            write_q          <= 1'b0;
            word_cnt_q       <= '0;
            tmr_q            <= '0;
            error            <= 1'b0;
            host.rdata_valid <= 1'b0;
            host.rdata_last  <= 1'b0;
            host.rdata       <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= host.cmd_addr;
                len_q   <= len_clamped;
                write_q <= host.cmd_write;
            end
            if (state_q != WRITE && state_q != READ) begin
                word_cnt_q <= '0;
                tmr_q      <= '0;
            end else if (word_event) begin
                word_cnt_q <= word_cnt_q + SDRC_LEN_W'(1);
                tmr_q      <= '0;
            end else begin
                tmr_q <= tmr_q + TW'(1);
            end
            if (timeout) error <= 1'b1;
            host.rdata_valid <= (state_q == READ) && sdrc_rd_valid;
            host.rdata_last  <= (state_q == READ) && sdrc_rd_valid && last_word;
            if ((state_q == READ) && sdrc_rd_valid) host.rdata <= sdrc_data_read;
        end
    end

endmodule

// File: tb/tb_sdrc_burst_initiator.sv
// Directed bench for sdrc_burst_initiator with a small SDRC-side responder.
module tb_sdrc_burst_initiator;
    import sdrc_burst_initiator_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    always #5 clock = ~clock;

    sdrc_burst_initiator_if bus();

    logic        busy, error;
    state_t      fsm_state;
    logic        sdrc_wr_n, sdrc_rd_n;
    logic [20:0] sdrc_addr;
    logic [6:0]  sdrc_data_len;
    logic [3:0]  sdrc_dqm;
    logic [31:0] sdrc_data_write;
    logic        sdrc_self_refresh, sdrc_power_down;
    logic [31:0] sdrc_data_read = '0;
    logic        sdrc_init_done = 1'b1;
    logic        sdrc_busy_n = 1'b1;
    logic        sdrc_rd_valid = 1'b0;
    logic        sdrc_wrd_ack = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int wr_strobes = 0;
    int rd_strobes = 0;
    int last_cnt = 0;
    int last_idx = 0;
    logic [6:0]  strobe_len = '0;
    logic [20:0] strobe_addr = '0;
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    logic [31:0] rd_q[$];

    sdrc_burst_initiator #(.MAX_WORDS(16), .TIMEOUT_CYCLES(255)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .host              (bus.slave),
        .busy              (busy),
        .error             (error),
        .fsm_state         (fsm_state),
        .sdrc_wr_n         (sdrc_wr_n),
        .sdrc_rd_n         (sdrc_rd_n),
        .sdrc_addr         (sdrc_addr),
        .sdrc_data_len     (sdrc_data_len),
        .sdrc_dqm          (sdrc_dqm),
        .sdrc_data_write   (sdrc_data_write),
        .sdrc_self_refresh (sdrc_self_refresh),
        .sdrc_power_down   (sdrc_power_down),
        .sdrc_data_read    (sdrc_data_read),
        .sdrc_init_done    (sdrc_init_done),
        .sdrc_busy_n       (sdrc_busy_n),
        .sdrc_rd_valid     (sdrc_rd_valid),
        .sdrc_wrd_ack      (sdrc_wrd_ack)
    );

    // Inputs change 1 ns after posedge, so everything is settled at negedge.
    always @(negedge clock) begin
        if (!sdrc_wr_n) begin
            wr_strobes++;
            strobe_len  = sdrc_data_len;
            strobe_addr = sdrc_addr;
        end
        if (!sdrc_rd_n) rd_strobes++;
        if (bus.rdata_valid) begin
            rd_q.push_back(bus.rdata);
            if (bus.rdata_last) begin
                last_cnt++;
                last_idx = rd_q.size();
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_wr_n"},        sdrc_wr_n, 1);
        check({tag, "_rd_n"},        sdrc_rd_n, 1);
        check({tag, "_cmd_ready"},   bus.cmd_ready, 0);
        check({tag, "_wdata_ready"}, bus.wdata_ready, 0);
        check({tag, "_rdata_valid"}, bus.rdata_valid, 0);
        check({tag, "_rdata_last"},  bus.rdata_last, 0);
        check({tag, "_busy"},        busy, 0);
        check({tag, "_error"},       error, 0);
        check({tag, "_addr"},        sdrc_addr, 0);
        check({tag, "_len"},         sdrc_data_len, 0);
        check({tag, "_rdata"},       bus.rdata, 0);
    endtask

    task automatic send_cmd(input logic wr, input logic [20:0] a, input logic [5:0] l);
        int n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = a;
        bus.cmd_len   = l;
        @(negedge clock);
        while (!bus.cmd_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("cmd_accept", n < 100, 1);
        cyc();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic push_words(input int cnt, input logic [31:0] base);
        for (int i = 0; i < cnt; i++) begin
            int n = 0;
            bus.wdata_valid = 1'b1;
            bus.wdata       = base + 32'(i);
            @(negedge clock);
            while (!bus.wdata_ready && n < 100) begin
                @(negedge clock);
                n++;
            end
            check("wdata_accept", n < 100, 1);
            cyc();
        end
        bus.wdata_valid = 1'b0;
    endtask

    task automatic wait_strobe(input bit rd);
        int n = 0;
        @(negedge clock);
        while ((rd ? sdrc_rd_n : sdrc_wr_n) && n < 400) begin
            @(negedge clock);
            n++;
        end
        check(rd ? "rd_strobe_seen" : "wr_strobe_seen", n < 400, 1);
    endtask

    task automatic do_acks(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            sdrc_wrd_ack = 1'b1;
            @(negedge clock);
            got_q.push_back(sdrc_data_write);
            cyc();
        end
        sdrc_wrd_ack = 1'b0;
    endtask

    initial begin
        int n;
        int acc;
        int s0;
        int r0;
        logic [31:0] wv;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr = '0;
        bus.cmd_len = '0;
        bus.wdata_valid = 1'b0;
        bus.wdata = '0;

        // Reset values, including cmd_ready held low despite init_done=1
        repeat (3) cyc();
        @(negedge clock);
        check_reset("rst");
        check("rst_dqm", sdrc_dqm, 0);
        check("rst_self_refresh", sdrc_self_refresh, 0);
        check("rst_power_down", sdrc_power_down, 0);
        cyc();
        reset_n = 1'b1;
        cyc();

        // Write burst: 4 words at 0x00100
        send_cmd(1'b1, 21'h00100, 6'd3);
        push_words(4, 32'hA0);
        wait_strobe(1'b0);
        check("w1_strobe_len", sdrc_data_len, 3);
        check("w1_strobe_addr", sdrc_addr, 21'h00100);
        cyc();
        do_acks(4);
        @(negedge clock);
        check("w1_busy_fall", busy, 0);
        check("w1_strobe_count", wr_strobes, 1);
        check("w1_word_count", got_q.size(), 4);
        exp_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        for (int i = 0; i < 4 && i < got_q.size(); i++) check("w1_data", got_q[i], exp_q[i]);
        got_q.delete();

        // Stray ack / rd_valid while idle
        cyc();
        sdrc_wrd_ack = 1'b1;
        sdrc_rd_valid = 1'b1;
        cyc();
        cyc();
        sdrc_wrd_ack = 1'b0;
        sdrc_rd_valid = 1'b0;
        cyc();
        @(negedge clock);
        check("stray_no_rdata", rd_q.size(), 0);
        check("stray_idle", 32'(fsm_state), 32'(IDLE));

        // Read burst: 8 words at the top address with one-cycle gaps
        cyc();
        send_cmd(1'b0, 21'h1FFFFF, 6'd7);
        wait_strobe(1'b1);
        check("r1_strobe_addr", sdrc_addr, 21'h1FFFFF);
        check("r1_strobe_len", sdrc_data_len, 7);
        cyc();
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            sdrc_rd_valid = 1'b1;
            sdrc_data_read = 32'hD000_0000 + 32'(i);
            exp_q.push_back(32'hD000_0000 + 32'(i));
            cyc();
            sdrc_rd_valid = 1'b0;
            cyc();
        end
        cyc();
        @(negedge clock);
        check("r1_word_count", rd_q.size(), 8);
        for (int i = 0; i < 8 && i < rd_q.size(); i++) check("r1_data", rd_q[i], exp_q[i]);
        check("r1_last_count", last_cnt, 1);
        check("r1_last_index", last_idx, 8);
        check("r1_busy_fall", busy, 0);
        rd_q.delete();

        // ISSUE held off by sdrc_busy_n for 50 cycles
        cyc();
        sdrc_busy_n = 1'b0;
        send_cmd(1'b0, 21'h00042, 6'd1);
        s0 = rd_strobes;
        repeat (50) cyc();
        @(negedge clock);
        check("hold_no_strobe", rd_strobes, s0);
        check("hold_busy", busy, 1);
        check("hold_state", 32'(fsm_state), 32'(ISSUE));
        cyc();
        sdrc_busy_n = 1'b1;
        #1;
        check("hold_strobe_first", sdrc_rd_n, 0);
        cyc();
        sdrc_rd_valid = 1'b1;
        sdrc_data_read = 32'hE0;
        cyc();
        sdrc_data_read = 32'hE1;
        cyc();
        sdrc_rd_valid = 1'b0;
        repeat (3) cyc();
        @(negedge clock);
        check("hold_strobe_once", rd_strobes, s0 + 1);
        check("hold_last_count", last_cnt, 2);
        check("hold_busy_fall", busy, 0);
        rd_q.delete();

        // Read timeout after 2 of 4 words
        cyc();
        send_cmd(1'b0, 21'h00200, 6'd3);
        wait_strobe(1'b1);
        cyc();
        sdrc_rd_valid = 1'b1;
        sdrc_data_read = 32'hF0;
        cyc();
        sdrc_data_read = 32'hF1;
        cyc();
        sdrc_rd_valid = 1'b0;
        n = 0;
        while (!error && n < 400) begin
            @(negedge clock);
            n++;
        end
        check("to_error", error, 1);
        check("to_window", (n >= 250 && n <= 260), 1);
        check("to_state_idle", 32'(fsm_state), 32'(IDLE));
        check("to_cmd_ready", bus.cmd_ready, 1);
        check("to_no_last", last_cnt, 2);
        check("to_words", rd_q.size(), 2);

        // cmd_len=40 clamps to 16 words; error stays sticky
        cyc();
        send_cmd(1'b1, 21'h0ABCD, 6'd40);
        s0 = wr_strobes;
        acc = 0;
        wv = 32'h100;
        bus.wdata_valid = 1'b1;
        bus.wdata = wv;
        for (int i = 0; i < 25; i++) begin
            bit took;
            @(negedge clock);
            took = bus.wdata_ready;
            if (took) acc++;
            cyc();
            if (took) begin
                wv = wv + 32'd1;
                bus.wdata = wv;
            end
        end
        bus.wdata_valid = 1'b0;
        @(negedge clock);
        check("clamp_accepted", acc, 16);
        check("clamp_strobe_count", wr_strobes, s0 + 1);
        check("clamp_len", strobe_len, 15);
        check("clamp_addr", strobe_addr, 21'h0ABCD);
        got_q.delete();
        cyc();
        do_acks(16);
        @(negedge clock);
        check("clamp_busy_fall", busy, 0);
        check("clamp_words", got_q.size(), 16);
        for (int i = 0; i < 16 && i < got_q.size(); i++) check("clamp_data", got_q[i], 32'h100 + 32'(i));
        check("error_sticky", error, 1);

        // init_done low blocks commands
        cyc();
        sdrc_init_done = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        #1;
        check("nodone_cmd_ready", bus.cmd_ready, 0);
        cyc();
        cyc();
        check("nodone_busy", busy, 0);
        bus.cmd_valid = 1'b0;
        sdrc_init_done = 1'b1;

        // Reset mid-write after two acks, then a clean write
        cyc();
        send_cmd(1'b1, 21'h00300, 6'd3);
        push_words(4, 32'h11);
        wait_strobe(1'b0);
        cyc();
        do_acks(2);
        got_q.delete();
        reset_n = 1'b0;
        #1;
        check_reset("mid");
        check("mid_state", 32'(fsm_state), 32'(IDLE));
        repeat (2) cyc();
        reset_n = 1'b1;
        s0 = wr_strobes;
        r0 = rd_q.size();
        repeat (5) cyc();
        @(negedge clock);
        check("post_no_wr_strobe", wr_strobes, s0);
        check("post_no_rdata", rd_q.size(), r0);
        check("post_busy", busy, 0);
        cyc();
        send_cmd(1'b1, 21'h00400, 6'd1);
        push_words(2, 32'h55);
        wait_strobe(1'b0);
        check("post_len", sdrc_data_len, 1);
        check("post_addr", sdrc_addr, 21'h00400);
        cyc();
        do_acks(2);
        @(negedge clock);
        check("post_busy_fall", busy, 0);
        check("post_words", got_q.size(), 2);
        exp_q = '{32'h55, 32'h56};
        for (int i = 0; i < 2 && i < got_q.size(); i++) check("post_data", got_q[i], exp_q[i]);
        check("post_error_clear", error, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sdrc_burst_initiator.md
SDRC_BURST_INITIATOR -- requirements
Module: sdrc_burst_initiator

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 16, meaning burst buffer depth in 32-bit words (power of two, 2..64).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning maximum wait for completion before error.
REQ-003 SHALL have ports: clock input 1 (sole clock); reset_n input 1 (asynchronous, active-low).
REQ-004 SHALL have ports: cmd_valid in 1; cmd_ready out 1; cmd_write in 1 (1=write, 0=read); cmd_addr in 21 (word address); cmd_len in 6 (words minus 1).
REQ-005 SHALL have ports: wdata_valid in 1; wdata_ready out 1; wdata in 32; rdata_valid out 1; rdata out 32; rdata_last out 1 (no backpressure); busy out 1; error out 1 (sticky timeout).
REQ-006 SHALL have SDRC-side ports: sdrc_wr_n out 1; sdrc_rd_n out 1; sdrc_addr out 21; sdrc_data_len out 7; sdrc_dqm out 4; sdrc_data_write out 32; sdrc_self_refresh out 1; sdrc_power_down out 1.
REQ-007 SHALL have SDRC-side inputs: sdrc_data_read 32; sdrc_init_done 1; sdrc_busy_n 1; sdrc_rd_valid 1; sdrc_wrd_ack 1.

Function
REQ-008 SHALL implement FSM states IDLE, FILL, ISSUE, WRITE, READ.
REQ-009 IDLE: cmd_ready=1 only when sdrc_init_done=1; a cmd_valid&&cmd_ready cycle latches addr/len/write and moves to FILL (write) or ISSUE (read).
REQ-010 cmd_len values >= MAX_WORDS SHALL be clamped to MAX_WORDS-1.
REQ-011 FILL: wdata_ready=1 while the buffer holds fewer than len+1 words; each wdata_valid&&wdata_ready pushes one word; on the push of word len, move to ISSUE next cycle.
REQ-012 ISSUE: when sdrc_busy_n=1, drive sdrc_wr_n=0 (write) or sdrc_rd_n=0 (read) for exactly one cycle, with sdrc_addr and sdrc_data_len={1'b0,len} valid that same cycle; then enter WRITE or READ.
REQ-013 ISSUE with sdrc_busy_n=0 SHALL hold the strobes high and wait, without a timeout.
REQ-014 WRITE: sdrc_data_write SHALL equal the buffer head at all times; each cycle with sdrc_wrd_ack=1 pops one word; after len+1 pops, return to IDLE.
REQ-015 READ: each cycle with sdrc_rd_valid=1 SHALL produce rdata_valid=1 and rdata=sdrc_data_read one cycle later (registered); rdata_last=1 on word len; afterwards return to IDLE.
REQ-016 sdrc_wrd_ack in a non-WRITE state, or sdrc_rd_valid in a non-READ state, SHALL be ignored.
REQ-017 In WRITE/READ, a counter SHALL reset on each ack/valid; reaching TIMEOUT_CYCLES sets error=1, flushes the buffer and returns to IDLE; in READ, no rdata_last is emitted.
REQ-018 error SHALL clear only on reset.
REQ-019 busy SHALL be 1 in every state except IDLE.
REQ-020 sdrc_dqm SHALL be constant 4'b0000; sdrc_self_refresh and sdrc_power_down SHALL be constant 0.
REQ-021 Word counters SHALL be 7 bits wide; the buffer pointers SHALL wrap modulo MAX_WORDS.

Reset
REQ-022 reset_n=0 SHALL asynchronously force IDLE and clear the buffer and counters.
REQ-023 Reset SHALL set the outputs to: sdrc_wr_n=1, sdrc_rd_n=1, cmd_ready=0, wdata_ready=0, rdata_valid=0, rdata_last=0, busy=0, error=0, sdrc_addr=0, sdrc_data_len=0, rdata=0.
REQ-024 Reset asserted mid-burst SHALL abandon the burst; after release, no residual strobe or rdata SHALL be emitted.

Structure
REQ-025 The shared package SHALL hold the state enum, SDRC_ADDR_W=21, SDRC_DATA_W=32 and SDRC_LEN_W=7.
REQ-026 The buffer SHALL be one sub-module, sdrc_word_fifo (synchronous FIFO, show-ahead head, push/pop/flush, count output).

Verification
REQ-027 Write cmd_addr=0x00100, cmd_len=3, four words 0xA0..0xA3 -> one sdrc_wr_n low cycle with sdrc_data_len=3; the model captures 0xA0..0xA3 in order; busy then falls.
REQ-028 Read cmd_addr=0x1FFFFF, cmd_len=7, model returns 8 words with one-cycle gaps -> 8 rdata_valid pulses, rdata matching, rdata_last only on the 8th.
REQ-029 sdrc_busy_n held 0 for 50 cycles in ISSUE -> strobe asserts on the first cycle busy_n=1, exactly once.
REQ-030 Read where the model stops after 2 of 4 words -> error=1 after 255 idle cycles, state IDLE, cmd_ready=1, no rdata_last.
REQ-031 cmd_len=40 with MAX_WORDS=16 -> 16 words accepted, sdrc_data_len=15; sdrc_init_done=0 -> cmd_ready=0.
REQ-032 reset_n pulsed during WRITE after 2 acks -> all outputs take their reset values immediately; the next write completes correctly.
